// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - natural-order ping-pong reorder buffer for the FFT output
// Frames are captured by natural bin index into one RAM bank and streamed out in order from the other.
module fft_reorder #(
  parameter int N     = 1024,
  parameter int WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    en_i,
  input  logic [$clog2(N)-1:0]    ctr_i,
  input  logic signed [WIDTH-1:0] re_i,
  input  logic signed [WIDTH-1:0] im_i,
  output logic                    valid_o,
  output logic [$clog2(N)-1:0]    ctr_o,
  output logic                    last_o,
  output logic signed [WIDTH-1:0] re_o,
  output logic signed [WIDTH-1:0] im_o,
  output logic                    overrun_o
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  typedef enum logic {IDLE, READ} state_t;

  logic [AW-1:0]        wr_cnt;
  logic                 wr_sel;
  logic                 drop;
  logic [1:0]           bank_full;
  logic [1:0]           bank_full_nxt;
  state_t               state;
  logic                 rd_sel;
  logic [AW-1:0]        rd_addr;
  logic [2*WIDTH-1:0]   mem [2*N];
  logic [2*WIDTH-1:0]   ram_q;
  logic                 p1_valid;
  logic [AW-1:0]        p1_ctr;
  logic                 wr_en;
  logic                 set_full;
  logic                 rd_last;

  always_comb begin
    wr_en    = en_i && !drop && !bank_full[wr_sel];
    set_full = en_i && (wr_cnt == CNT_LAST) && !drop;
    rd_last  = (state == READ) && (rd_addr == CNT_LAST);
    bank_full_nxt = bank_full;
    // Set and clear never hit the same bank: writes only target an empty bank, reads only a full one.
    if (set_full) bank_full_nxt[wr_sel] = 1'b1;
    if (rd_last)  bank_full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_sel    <= 1'b0;
      wr_cnt    <= '0;
      drop      <= 1'b0;
      overrun_o <= 1'b0;
    end else if (en_i) begin
      if (wr_cnt == CNT_LAST) begin
        wr_cnt <= '0;
        drop   <= 1'b0;
        if (!drop) wr_sel <= ~wr_sel;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
        // A frame that starts while its bank is still being read out is discarded whole.
        if ((wr_cnt == '0) && bank_full[wr_sel]) begin
          drop      <= 1'b1;
          overrun_o <= 1'b1;
        end
      end
    end else if (wr_cnt != '0) begin
      wr_cnt <= '0;
      drop   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_sel, ctr_i}] <= {re_i, im_i};
    ram_q <= mem[{rd_sel, rd_addr}];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= IDLE;
      rd_sel  <= 1'b0;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bank_full[rd_sel]) begin
            state   <= READ;
            rd_addr <= '0;
          end
        end
        READ: begin
          if (rd_addr == CNT_LAST) begin
            rd_sel  <= ~rd_sel;
            rd_addr <= '0;
            if (!bank_full[~rd_sel]) state <= IDLE;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      p1_valid <= 1'b0;
      p1_ctr   <= '0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      ctr_o    <= '0;
      re_o     <= '0;
      im_o     <= '0;
    end else begin
      p1_valid <= (state == READ);
      p1_ctr   <= rd_addr;
      valid_o  <= p1_valid;
      last_o   <= p1_valid && (p1_ctr == CNT_LAST);
      if (p1_valid) begin
        ctr_o <= p1_ctr;
        re_o  <= ram_q[2*WIDTH-1:WIDTH];
        im_o  <= ram_q[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - scoreboard bench for fft_reorder with N=16
module tb_fft_reorder;

  localparam int N = 16;
  localparam int W = 24;

  logic                clk = 1'b0;
  logic                srst;
  logic                en_i;
  logic [3:0]          ctr_i;
  logic signed [W-1:0] re_i;
  logic signed [W-1:0] im_i;
  logic                valid_o;
  logic [3:0]          ctr_o;
  logic                last_o;
  logic signed [W-1:0] re_o;
  logic signed [W-1:0] im_o;
  logic                overrun_o;

  fft_reorder #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .srst(srst), .en_i(en_i), .ctr_i(ctr_i), .re_i(re_i), .im_i(im_i),
    .valid_o(valid_o), .ctr_o(ctr_o), .last_o(last_o), .re_o(re_o), .im_o(im_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]          ctr;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_in_cyc = 0;
  int   first_valid_cyc = 0;
  int   rises = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic send_frame(input int base, input int first, input int last, input bit push);
    exp_t e;
    for (int i = first; i < last; i++) begin
      @(posedge clk); #1;
      en_i  = 1'b1;
      ctr_i = rev4(4'(i));
      re_i  = W'(base + int'(rev4(4'(i))));
      im_i  = -re_i;
      last_in_cyc = cyc;
    end
    if (push) begin
      for (int k = 0; k < N; k++) begin
        e.ctr = 4'(k);
        e.re  = W'(base + k);
        e.im  = -e.re;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      en_i = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || valid_o) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(valid_o), 64'd0);
    check({tag, "_last"}, 64'(last_o), 64'd0);
    check({tag, "_ctr"}, 64'(ctr_o), 64'd0);
    check({tag, "_re"}, 64'(re_o), 64'd0);
    check({tag, "_im"}, 64'(im_o), 64'd0);
    check({tag, "_ovr"}, 64'(overrun_o), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!srst) begin
      if (valid_o) begin
        if (q.size() == 0) begin
          check("unexp_valid", 64'(valid_o), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_ctr", 64'(ctr_o), 64'(e.ctr));
          check("out_re", 64'(re_o), 64'(e.re));
          check("out_im", 64'(im_o), 64'(e.im));
          check("out_last", 64'(last_o), 64'(e.ctr == 4'd15));
        end
        if (!prev_v) begin
          rises++;
          first_valid_cyc = cyc;
        end
      end
      prev_v = valid_o;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t_last;
    int r0;
    srst  = 1'b1;
    en_i  = 1'b0;
    ctr_i = '0;
    re_i  = '0;
    im_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("rst");
    @(posedge clk); #1;
    srst = 1'b0;

    // single frame: latency, order, last flag
    r0 = rises;
    send_frame(0, 0, N, 1'b1);
    t_last = last_in_cyc;
    idle(1);
    drain();
    check("lat", 64'(first_valid_cyc - t_last), 64'd4);
    check("single_runs", 64'(rises - r0), 64'd1);

    // mid-stream reset during read-out and a partial write
    send_frame(200, 0, N, 1'b1);
    send_frame(300, 0, 8, 1'b0);
    srst = 1'b1;
    en_i = 1'b0;
    q.delete();
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_rst");
    idle(40);

    // three gapped frames
    for (int f = 0; f < 3; f++) begin
      send_frame(16 * f, 0, N, 1'b1);
      idle(1);
    end
    drain();
    check("gapped_ovr", 64'(overrun_o), 64'd0);

    // aborted partial frame then a full frame
    send_frame(500, 0, 5, 1'b0);
    idle(1);
    send_frame(600, 0, N, 1'b1);
    idle(1);
    drain();
    check("abort_ovr", 64'(overrun_o), 64'd0);

    // overrun: third gapless frame dropped
    r0 = rises;
    send_frame(1000, 0, N, 1'b1);
    send_frame(2000, 0, N, 1'b1);
    send_frame(3000, 0, 1, 1'b0);
    @(negedge clk);
    check("ovr_early", 64'(overrun_o), 64'd0);
    @(negedge clk);
    check("ovr_rise", 64'(overrun_o), 64'd1);
    send_frame(3000, 2, N, 1'b0);
    idle(1);
    send_frame(4000, 0, N, 1'b1);
    idle(1);
    drain();
    check("ovr_sticky", 64'(overrun_o), 64'd1);
    check("ovr_runs", 64'(rises - r0), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Natural-order reorder buffer placed directly downstream of the radix-2^2 FFT. It captures each N-point output frame, which arrives in bit-reversed order, into one half of a ping-pong RAM, indexed by the natural-order bin counter that accompanies the data. It then streams the frame out in natural bin order (0..N-1) while the next frame fills the other half. Downstream consumers are the magnitude/peak-detect path and the host FIFO.

## Interface
- N, 1024, FFT length; power of 4, matches the FFT.
- WIDTH, 24, sample component width; matches the FFT OUTPUT_WIDTH.
- clk  in  1  single clock domain.
- srst  in  1  synchronous, active-high reset.
- en_i  in  1  input sample valid; the FFT valid output.
- ctr_i  in  $clog2(N)  natural bin index of the input sample; the FFT data_ctr_o.
- re_i, im_i  in  WIDTH (signed)  input sample.
- valid_o  out  1  output sample valid.
- ctr_o  out  $clog2(N)  natural bin index of the output sample.
- last_o  out  1  high with bin N-1.
- re_o, im_o  out  WIDTH (signed)  output sample.
- overrun_o  out  1  sticky flag: a frame was dropped.

## Operation
- Storage is a single dual-port RAM of depth 2N and width 2*WIDTH.
  - Address is {bank, idx}.
  - Synchronous read with 1-cycle latency.
  - Contents are not reset.
- Write side registers: wr_sel (bank being filled), wr_cnt (accepted samples in the current frame), drop (current frame discarded), bank_full[1:0].
  - en_i high, drop low, bank_full[wr_sel] low: write {re_i,im_i} to {wr_sel, ctr_i}; wr_cnt++.
  - en_i high, wr_cnt==N-1: set bank_full[wr_sel]; toggle wr_sel; wr_cnt<=0. The write of the final sample still occurs.
  - Frame start (en_i high, wr_cnt==0) with bank_full[wr_sel] high:
    - set drop and overrun_o;
    - suppress all writes for this frame;
    - wr_cnt still counts;
    - at wr_cnt==N-1: clear drop, wr_cnt<=0, wr_sel unchanged.
  - en_i low with wr_cnt!=0 (abort):
    - wr_cnt<=0 and drop<=0;
    - partial bank is not marked full;
    - wr_sel is unchanged, so the next frame overwrites the partial bank.
- Read FSM, state IDLE:
  - if bank_full[rd_sel], go to READ with rd_addr<=0;
  - otherwise stay in IDLE.
- Read FSM, state READ:
  - issue read {rd_sel, rd_addr} each cycle; rd_addr++.
  - At rd_addr==N-1: clear bank_full[rd_sel] and toggle rd_sel.
    - If bank_full[~rd_sel] is high, stay in READ with rd_addr<=0 (gapless).
    - Otherwise go to IDLE.
- Bank arbitration: set and clear of bank_full in the same cycle always target different banks; both take effect.
- Output pipeline:
  - rd_addr/issue flag are registered alongside RAM latency, then the output register drives valid_o, ctr_o, last_o, re_o, im_o.
  - No arithmetic; data is passed bit-exact.
- overrun_o clears only on srst.

## Timing
- Reset values (the cycle after srst is sampled high):
  - valid_o=0, last_o=0, ctr_o=0, re_o=0, im_o=0, overrun_o=0;
  - state=IDLE, wr_sel=0, rd_sel=0, wr_cnt=0, drop=0, bank_full=0.
- srst mid-frame: any in-progress write frame and read-out are abandoned. No valid_o until a complete new frame is captured.
- Latency: with the final input sample at cycle t:
  - bank_full is visible at t+1;
  - READ issues address 0 at t+2;
  - valid_o with ctr_o=0 is high at t+4.
- valid_o is high for exactly N consecutive cycles per frame, with ctr_o=0..N-1 and last_o at N-1.
- Back-to-back output frames are contiguous; there are no idle cycles between them.
- Throughput: sustained operation requires at least 1 idle en_i cycle between every input frame.
  - Two consecutive gapless frames are accepted.
  - A third gapless frame finds its bank still full and is dropped.

## Test plan
- Reset: assert srst mid-stream -> all outputs 0 on the next cycle; no valid_o afterwards until a new full frame completes.
- Single frame, N=16, bit-reversed ctr_i, re_i=k, im_i=-k at bin k:
  - valid_o high for 16 cycles starting 4 cycles after the last input;
  - ctr_o=re_o=0..15, im_o=-ctr_o;
  - last_o only at 15.
- Three frames, N=16, 1-cycle gaps, frame f with re_i=16f+k -> 48 contiguous-or-IDLE-separated outputs in natural order, correct per-frame values, overrun_o=0.
- Abort: en_i drops after 5 samples, then a full frame follows -> only the full frame appears at the output, correct values, overrun_o=0.
- Overrun: three gapless frames, N=16 ->
  - frames 1 and 2 are output intact;
  - frame 3 produces no output;
  - overrun_o rises the cycle after frame 3's first sample and stays high;
  - a subsequent gapped frame 4 is output correctly.
